// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for the Execute stage: one quotient bit per cycle,
// with signed operands handled as magnitudes and the signs restored once the result is ready.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    input  logic        stall_ext,
    output logic [63:0] result,
    output logic        ready,
    output logic        div_stall
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] acc;
    logic [31:0] divisor;
    logic        q_neg;
    logic        r_neg;
    logic [4:0]  count;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [33:0] trial;
    logic [63:0] acc_step;
    logic [31:0] q_out;
    logic [31:0] r_out;

    // The shifted partial remainder can reach 33 bits, so the trial subtraction
    // works on acc[63:31] and a 34-bit difference whose top bit is the borrow.
    always_comb begin
        a_mag    = (signed_div && a[31]) ? (32'd0 - a) : a;
        b_mag    = (signed_div && b[31]) ? (32'd0 - b) : b;
        trial    = {1'b0, acc[63:31]} - {2'b00, divisor};
        acc_step = trial[33] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
        q_out    = q_neg ? (32'd0 - acc[31:0]) : acc[31:0];
        r_out    = r_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = BUSY;
            BUSY: if (count == 5'd31) state_next = DONE;
            DONE: if (!stall_ext) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (annul || rst) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            count   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        acc     <= {32'd0, a_mag};
                        divisor <= b_mag;
                        q_neg   <= signed_div & (a[31] ^ b[31]);
                        r_neg   <= signed_div & a[31];
                        count   <= '0;
                    end
                end
                BUSY: begin
                    if (!annul) begin
                        acc   <= acc_step;
                        count <= count + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result    = rst ? '0 : {r_out, q_out};
        ready     = (state == DONE) && !annul && !rst;
        div_stall = (((state == IDLE) && start) || (state == BUSY)) && !annul && !rst;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  divide instruction present in Execute stage; held high by pipeline while stalled.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE.
REQ-006 a  input  32  dividend; sampled with start in IDLE.
REQ-007 b  input  32  divisor; sampled with start in IDLE.
REQ-008 annul  input  1  exception flush of Execute; aborts any operation.
REQ-009 stall_ext  input  1  OR of instruction/data memory stalls; holds a finished result.
REQ-010 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-011 ready  output  1  result valid this cycle.
REQ-012 div_stall  output  1  request to hazard unit to freeze F/D/E/M/W.

Function
REQ-013 States SHALL be IDLE, BUSY, DONE; encoding free.
REQ-014 IDLE: start & ~annul -> BUSY; latch |a|, |b| (signed_div) or a, b raw, sign of quotient (a[31]^b[31]) and sign of remainder (a[31]), both forced 0 when unsigned; clear iteration counter.
REQ-015 BUSY: one restoring radix-2 step per cycle over a 64-bit partial-remainder/quotient register; counter 0..31; after step 31 -> DONE.
REQ-016 DONE: apply signs (quotient negated if quotient sign set, remainder negated if remainder sign set); ready = 1; stay in DONE while stall_ext = 1, else -> IDLE.
REQ-017 div_stall SHALL be combinational: ((IDLE & start) | BUSY) & ~annul; 0 in DONE.
REQ-018 Latency: start cycle + 32 BUSY cycles = 33 stall cycles; ready on cycle 34; pipeline advances at end of the DONE cycle with stall_ext = 0.
REQ-019 start is ignored in BUSY and DONE; it never restarts or re-samples operands.
REQ-020 After DONE -> IDLE, a start still high is treated as a new divide (a back-to-back divide is legal).
REQ-021 annul SHALL take priority over everything: next state IDLE from any state; ready forced 0 in that cycle; result undefined.
REQ-022 Divide by zero: no trap; the block produces the natural restoring result. Unsigned: quotient 0xFFFFFFFF, remainder a. Signed: signs then applied per REQ-016.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no error.
REQ-024 result SHALL be stable for every cycle ready = 1, including extended DONE.
REQ-025 All arithmetic SHALL be 32-bit two's complement; |0x80000000| = 0x80000000 as unsigned.

Reset
REQ-026 rst in any state: next state IDLE, counter 0, result 0, ready 0; div_stall 0 in the reset cycle and after.
REQ-027 rst mid-operation SHALL discard the operation; the next start begins a fresh divide.

Verification
REQ-028 DIVU a=100, b=7, start held until ready -> div_stall high 33 cycles; ready cycle 34; result = {0x00000002, 0x0000000E}.
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> result = {0xFFFFFFFF, 0xFFFFFFFD}; DIV a=0x80000000, b=0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-030 DIVU a=5, b=0 -> {0x00000005, 0xFFFFFFFF}; div_stall and ready timing identical to REQ-028.
REQ-031 annul pulsed on BUSY cycle 10 -> div_stall 0 in that same cycle; IDLE next cycle; ready never asserts; a following start of 9/3 returns {0, 3} after 34 cycles.
REQ-032 stall_ext high for 3 cycles at DONE -> ready high 4 cycles; result unchanged; no restart while start is held high.
REQ-033 rst asserted on BUSY cycle 5 -> ready 0, result 0, div_stall 0; next start 100/7 gives REQ-028 response.
